// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared types and defaults for the RAM arbiter:
//   state_e      - access sequencer states (IDLE, ISSUE, CAPTURE)
//   grant_sel_e  - which requester owns the current / last access
//   DEFAULT_PART_WIDTH, DEFAULT_PID_WIDTH - partition geometry defaults
package ram_arbiter_pkg;

  localparam int DEFAULT_PART_WIDTH = 9;  // 512-word partitions
  localparam int DEFAULT_PID_WIDTH  = 2;  // 4 partitions

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_sel_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles both requester ports and the RAM-side bus of the arbiter.
//   Requester side : Req/Write/Addr/Data/PID in, Ack/Fault out (A and B),
//                    shared Read_Data out.
//   RAM side       : Mem_Address/Mem_Write_Data/Mem_Write out,
//                    Mem_Read_Data in (registered RAM output).
// Modports:
//   slave  - the arbiter itself
//   master - the environment: both requesters plus the RAM
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int PID_WIDTH  = 2
);

  logic                  Req_A,   Req_B;
  logic                  Write_A, Write_B;
  logic [ADDR_WIDTH-1:0] Addr_A,  Addr_B;
  logic [DATA_WIDTH-1:0] Data_A,  Data_B;
  logic [PID_WIDTH-1:0]  PID_A,   PID_B;
  logic                  Ack_A,   Ack_B;
  logic                  Fault_A, Fault_B;
  logic [DATA_WIDTH-1:0] Read_Data;
  logic [ADDR_WIDTH-1:0] Mem_Address;
  logic [DATA_WIDTH-1:0] Mem_Write_Data;
  logic                  Mem_Write;
  logic [DATA_WIDTH-1:0] Mem_Read_Data;

  modport slave (
    input  Req_A, Req_B, Write_A, Write_B, Addr_A, Addr_B,
           Data_A, Data_B, PID_A, PID_B, Mem_Read_Data,
    output Ack_A, Ack_B, Fault_A, Fault_B, Read_Data,
           Mem_Address, Mem_Write_Data, Mem_Write
  );

  modport master (
    output Req_A, Req_B, Write_A, Write_B, Addr_A, Addr_B,
           Data_A, Data_B, PID_A, PID_B, Mem_Read_Data,
    input  Ack_A, Ack_B, Fault_A, Fault_B, Read_Data,
           Mem_Address, Mem_Write_Data, Mem_Write
  );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2
// Two-way round-robin picker (purely combinational).
//   eligible[0] = A, eligible[1] = B
//   last_grant  = requester served most recently
//   grant       = one-hot grant (bit0 = A, bit1 = B), zero when none eligible
// On contention the requester that was not served last wins.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  grant_sel_e last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == GRANT_A) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one registered-read data RAM between requester A (core) and
// requester B (I/O / loader) with round-robin arbitration. Each access is
// mapped into the 512-word partition chosen by its PID:
//   physical = {PID, Addr[PART_WIDTH-1:0]} zero-extended to ADDR_WIDTH.
// Every access takes three cycles: grant edge -> ISSUE -> CAPTURE -> Ack.
// Ports:
//   Fast_Clock - clock for all state
//   Reset      - synchronous, active-high
//   bus        - ram_arbiter_if.slave (requester ports + RAM bus)
// Build option:
//   RAM_ARBITER_BOUNDS_CHECK_EN - when defined, an access with nonzero upper
//   address bits is sequenced normally but suppresses the RAM write, returns
//   Read_Data = 0 and pulses Fault_x with Ack_x. When undefined the upper
//   bits are discarded and Fault_A/Fault_B stay 0.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int PART_WIDTH = DEFAULT_PART_WIDTH,
  parameter int PID_WIDTH  = DEFAULT_PID_WIDTH
) (
  input  logic               Fast_Clock,
  input  logic               Reset,
  ram_arbiter_if.slave       bus
);

  state_e                state_q, state_d;
  grant_sel_e            last_q, last_d;     // requester served last
  grant_sel_e            gsel_q, gsel_d;     // owner of the access in flight
  logic                  wr_q, wr_d;
  logic                  flt_q, flt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic                  fault_a_q, fault_a_d, fault_b_q, fault_b_d;

  logic [1:0]            eligible;
  logic [1:0]            grant;
  logic                  sel_b;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [PID_WIDTH-1:0]  sel_pid;
  logic [ADDR_WIDTH-1:0] sel_phys;
  logic                  sel_fault;

  // A requester whose Ack is high this cycle is still holding Req from the
  // access that is just completing, so it must not be granted again yet.
  assign eligible = {bus.Req_B & ~ack_b_q, bus.Req_A & ~ack_a_q};

  rr_pick2 u_pick (
    .eligible   (eligible),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign sel_b     = grant[1];
  assign sel_write = sel_b ? bus.Write_B : bus.Write_A;
  assign sel_addr  = sel_b ? bus.Addr_B  : bus.Addr_A;
  assign sel_data  = sel_b ? bus.Data_B  : bus.Data_A;
  assign sel_pid   = sel_b ? bus.PID_B   : bus.PID_A;
  assign sel_phys  = ADDR_WIDTH'({sel_pid, sel_addr[PART_WIDTH-1:0]});

`ifdef RAM_ARBITER_BOUNDS_CHECK_EN
  assign sel_fault = |sel_addr[ADDR_WIDTH-1:PART_WIDTH];
`else
  // Upper address bits wrap within the partition and are otherwise ignored.
  logic unused_upper_addr;
  assign unused_upper_addr = ^sel_addr[ADDR_WIDTH-1:PART_WIDTH];
  assign sel_fault = 1'b0;
`endif

  // State register
  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      last_q      <= GRANT_B;  // so A wins the first contention
      gsel_q      <= GRANT_A;
      wr_q        <= 1'b0;
      flt_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      fault_a_q   <= 1'b0;
      fault_b_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gsel_q      <= gsel_d;
      wr_q        <= wr_d;
      flt_q       <= flt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      fault_a_q   <= fault_a_d;
      fault_b_q   <= fault_b_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|grant) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic; everything lands in a register so the RAM and
  // requesters only ever see flop outputs.
  always_comb begin
    last_d      = last_q;
    gsel_d      = gsel_q;
    wr_d        = wr_q;
    flt_d       = flt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rdata_d     = rdata_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    fault_a_d   = 1'b0;
    fault_b_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          gsel_d      = sel_b ? GRANT_B : GRANT_A;
          wr_d        = sel_write;
          flt_d       = sel_fault;
          mem_addr_d  = sel_phys;
          mem_wdata_d = sel_data;
          // Registered here so the pulse is visible exactly in ISSUE.
          mem_we_d    = sel_write & ~sel_fault;
        end
      end
      CAPTURE: begin
        // RAM output now reflects the address presented during ISSUE.
        if (flt_q)      rdata_d = '0;
        else if (!wr_q) rdata_d = bus.Mem_Read_Data;
        ack_a_d   = (gsel_q == GRANT_A);
        ack_b_d   = (gsel_q == GRANT_B);
        fault_a_d = flt_q & (gsel_q == GRANT_A);
        fault_b_d = flt_q & (gsel_q == GRANT_B);
        last_d    = gsel_q;
      end
      default: ;
    endcase
  end

  assign bus.Ack_A          = ack_a_q;
  assign bus.Ack_B          = ack_b_q;
  assign bus.Fault_A        = fault_a_q;
  assign bus.Fault_B        = fault_b_q;
  assign bus.Read_Data      = rdata_q;
  assign bus.Mem_Address    = mem_addr_q;
  assign bus.Mem_Write_Data = mem_wdata_q;
  assign bus.Mem_Write      = mem_we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter: directed scenarios with literal
// expectations, then randomized traffic on both ports. A transaction-level
// reference (grant time + fixed 3-cycle latency, plus a word-array memory)
// predicts every output each cycle.
module tb_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int PW = 9;
  localparam int IW = 2;

`ifdef RAM_ARBITER_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PID_WIDTH(IW)) bus ();

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PART_WIDTH(PW), .PID_WIDTH(IW)) dut (
    .Fast_Clock (clk),
    .Reset      (rst),
    .bus        (bus)
  );

  // RAM with registered read
  bit [DW-1:0] ram [0:2047];
  always @(posedge clk) begin
    if (bus.Mem_Write) ram[bus.Mem_Address[10:0]] <= bus.Mem_Write_Data;
    bus.Mem_Read_Data <= ram[bus.Mem_Address[10:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          model_valid = 0;
  int          edge_n = 0;
  bit          pend = 0;
  int          g_edge, p_side, last_side;
  bit          p_wr, p_flt;
  logic [DW-1:0] p_rdata;
  bit [DW-1:0] model_mem [0:2047];
  logic          exp_ack_a, exp_ack_b, exp_fault_a, exp_fault_b, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rdata;

  task automatic model_step();
    logic el_a, el_b, w, f;
    int side;
    logic [AW-1:0] a;
    logic [IW-1:0] pid;
    logic [DW-1:0] d;
    logic [10:0] phys;
    bit old_pend;
    if (rst) begin
      exp_ack_a = 0; exp_ack_b = 0; exp_fault_a = 0; exp_fault_b = 0; exp_we = 0;
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      last_side = 1; pend = 0; model_valid = 1;
      return;
    end
    if (!model_valid) return;
    el_a = bus.Req_A && !exp_ack_a;
    el_b = bus.Req_B && !exp_ack_b;
    old_pend = pend;
    exp_ack_a = 0; exp_ack_b = 0; exp_fault_a = 0; exp_fault_b = 0; exp_we = 0;
    // completion: acked two edges after the grant edge
    if (pend && edge_n == g_edge + 2) begin
      if (p_side == 0) begin exp_ack_a = 1; exp_fault_a = p_flt; end
      else             begin exp_ack_b = 1; exp_fault_b = p_flt; end
      if (p_flt)      exp_rdata = '0;
      else if (!p_wr) exp_rdata = p_rdata;
      last_side = p_side;
      pend = 0;
    end
    if (!old_pend && (el_a || el_b)) begin
      side = (el_a && el_b) ? ((last_side == 0) ? 1 : 0) : (el_b ? 1 : 0);
      w   = side ? bus.Write_B : bus.Write_A;
      a   = side ? bus.Addr_B  : bus.Addr_A;
      d   = side ? bus.Data_B  : bus.Data_A;
      pid = side ? bus.PID_B   : bus.PID_A;
      phys = {pid, a[8:0]};
      f = BOUNDS && (a[15:9] != 0);
      exp_addr  = {5'b0, phys};
      exp_wdata = d;
      exp_we    = w && !f;
      if (w && !f) model_mem[phys] = d;
      p_rdata = model_mem[phys];
      p_side = side; p_wr = w; p_flt = f;
      pend = 1; g_edge = edge_n;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      edge_n++;
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("ack_a",     bus.Ack_A,          exp_ack_a);
        check("ack_b",     bus.Ack_B,          exp_ack_b);
        check("fault_a",   bus.Fault_A,        exp_fault_a);
        check("fault_b",   bus.Fault_B,        exp_fault_b);
        check("mem_write", bus.Mem_Write,      exp_we);
        check("mem_addr",  bus.Mem_Address,    exp_addr);
        check("mem_wdata", bus.Mem_Write_Data, exp_wdata);
        check("read_data", bus.Read_Data,      exp_rdata);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_access(input bit side, input bit wr, input logic [IW-1:0] pid,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           output int lat, output logic we_c1, output logic we_late,
                           output logic [AW-1:0] addr_c1, output logic flt,
                           output logic [DW-1:0] rd, output logic other_ack);
    @(negedge clk);
    if (!side) begin
      bus.Write_A = wr; bus.PID_A = pid; bus.Addr_A = addr; bus.Data_A = data; bus.Req_A = 1;
    end else begin
      bus.Write_B = wr; bus.PID_B = pid; bus.Addr_B = addr; bus.Data_B = data; bus.Req_B = 1;
    end
    lat = 0; we_c1 = 0; we_late = 0; addr_c1 = '0; flt = 0; rd = '0; other_ack = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        we_c1 = bus.Mem_Write; addr_c1 = bus.Mem_Address;
      end else if (bus.Mem_Write) we_late = 1;
      if (side ? bus.Ack_A : bus.Ack_B) other_ack = 1;
      if (side ? bus.Ack_B : bus.Ack_A) begin
        lat = n;
        flt = side ? bus.Fault_B : bus.Fault_A;
        rd  = bus.Read_Data;
      end
    end
    if (side) bus.Req_B = 0; else bus.Req_A = 0;
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    rst = 1;
    repeat (n) @(negedge clk);
    rst = 0;
  endtask

  task automatic rand_req(input bit side);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 511));
    if (!side) begin
      bus.Write_A = 1'($urandom_range(0, 1)); bus.PID_A = IW'($urandom);
      bus.Addr_A = a; bus.Data_A = $urandom; bus.Req_A = 1;
    end else begin
      bus.Write_B = 1'($urandom_range(0, 1)); bus.PID_B = IW'($urandom);
      bus.Addr_B = a; bus.Data_B = $urandom; bus.Req_B = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic we_c1, we_late, flt, oth;
    logic [AW-1:0] a1;
    logic [DW-1:0] rd;
    bit got_a, got_b, done;

    bus.Req_A = 0; bus.Req_B = 0; bus.Write_A = 0; bus.Write_B = 0;
    bus.Addr_A = '0; bus.Addr_B = '0; bus.Data_A = '0; bus.Data_B = '0;
    bus.PID_A = '0; bus.PID_B = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    check("reset_ack_a",     bus.Ack_A,       0);
    check("reset_mem_write", bus.Mem_Write,   0);
    check("reset_mem_addr",  bus.Mem_Address, 0);
    check("reset_read_data", bus.Read_Data,   0);
    rst = 0;

    // single A write, PID 2, addr 5
    do_access(0, 1, 2'd2, 16'h0005, 32'hDEADBEEF, lat, we_c1, we_late, a1, flt, rd, oth);
    check("wr_latency", lat, 3);
    check("wr_addr_c1", a1, 16'h0405);
    check("wr_we_c1", we_c1, 1);
    check("wr_we_late", we_late, 0);

    // read it back
    do_access(0, 0, 2'd2, 16'h0005, 32'h0, lat, we_c1, we_late, a1, flt, rd, oth);
    check("rd_latency", lat, 3);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_other_ack", oth, 0);
    check("rd_we_c1", we_c1, 0);

    // both ports held high: acks alternate A,B,A,B at cycles 3,6,9,12
    pulse_reset(2);
    bus.Write_A = 0; bus.PID_A = 2'd0; bus.Addr_A = 16'd1; bus.Req_A = 1;
    bus.Write_B = 0; bus.PID_B = 2'd1; bus.Addr_B = 16'd2; bus.Req_B = 1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check("alt_ack_a", bus.Ack_A, (n == 3 || n == 9));
      check("alt_ack_b", bus.Ack_B, (n == 6 || n == 12));
    end
    bus.Req_B = 0;
    done = 0;
    for (int n = 0; n < 10 && !done; n++) begin
      @(negedge clk);
      if (bus.Ack_A) done = 1;
    end
    check("alt_tail_ack_a", done, 1);
    bus.Req_A = 0;

    // load Read_Data with a nonzero value, then B access with upper bits set
    do_access(0, 0, 2'd2, 16'h0005, 32'h0, lat, we_c1, we_late, a1, flt, rd, oth);
    check("pre_rd_data", rd, 32'hDEADBEEF);
    do_access(1, 1, 2'd3, 16'h0200, 32'h12345678, lat, we_c1, we_late, a1, flt, rd, oth);
    check("oob_latency", lat, 3);
`ifdef RAM_ARBITER_BOUNDS_CHECK_EN
    check("oob_we", we_c1, 0);
    check("oob_fault", flt, 1);
    check("oob_read_data", rd, 0);
`else
    check("wrap_addr", a1, 16'h0600);
    check("wrap_we", we_c1, 1);
    check("wrap_fault", flt, 0);
    do_access(1, 0, 2'd3, 16'h0000, 32'h0, lat, we_c1, we_late, a1, flt, rd, oth);
    check("wrap_rd_data", rd, 32'h12345678);
`endif

    // make A the last-served requester, then abort a write in ISSUE
    do_access(0, 0, 2'd2, 16'h0005, 32'h0, lat, we_c1, we_late, a1, flt, rd, oth);
    @(negedge clk);
    bus.Write_A = 1; bus.PID_A = 2'd1; bus.Addr_A = 16'd7; bus.Data_A = 32'hCAFEF00D; bus.Req_A = 1;
    @(negedge clk);
    check("abort_we_issue", bus.Mem_Write, 1);
    rst = 1; bus.Req_A = 0;
    @(negedge clk);
    check("abort_we_after", bus.Mem_Write, 0);
    check("abort_ack_a", bus.Ack_A, 0);
    check("abort_ack_b", bus.Ack_B, 0);
    check("abort_addr", bus.Mem_Address, 0);
    rst = 0;
    bus.Write_A = 0; bus.Req_A = 1;
    bus.Write_B = 0; bus.PID_B = 2'd0; bus.Addr_B = 16'd0; bus.Req_B = 1;
    got_a = 0; got_b = 0; done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus.Ack_A || bus.Ack_B) begin
        got_a = bus.Ack_A; got_b = bus.Ack_B; done = 1;
      end
    end
    check("post_reset_first_a", got_a, 1);
    check("post_reset_first_b", got_b, 0);
    bus.Req_A = 0;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus.Ack_B) done = 1;
    end
    check("post_reset_b_served", done, 1);
    bus.Req_B = 0;

    // randomized traffic on both ports, one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) rst = 1;
      else rst = 0;
      if (bus.Req_A && bus.Ack_A) bus.Req_A = 0;
      else if (!bus.Req_A && $urandom_range(0, 3) == 0) rand_req(0);
      if (bus.Req_B && bus.Ack_B) bus.Req_B = 0;
      else if (!bus.Req_B && $urandom_range(0, 3) == 0) rand_req(1);
    end
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.Req_A && bus.Ack_A) bus.Req_A = 0;
      if (bus.Req_B && bus.Ack_B) bus.Req_B = 0;
      @(negedge clk);
    end
    bus.Req_A = 0; bus.Req_B = 0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single data RAM between two requesters, port A (core load/store) and port B (I/O / program loader), with round-robin arbitration. Each access carries a process ID that selects a 512-word partition of the 2048-word RAM. The block translates the logical address into a physical RAM address and sequences the RAM's registered read. It sits between the requesters and the RAM's Address / Write_Data / Mem_Write / Read_Data ports.

## Interface
- DATA_WIDTH, 32: word width on all data ports.
- ADDR_WIDTH, 16: logical address width from requesters and physical address width to RAM.
- PART_WIDTH, 9: log2 of partition size (512 words).
- PID_WIDTH, 2: process ID width (4 partitions).

Ports:
- Fast_Clock  in  1  single clock for all state.
- Reset  in  1  synchronous, active-high.
- Req_A / Req_B  in  1  access request; held high until the matching Ack.
- Write_A / Write_B  in  1  1 = write, 0 = read; stable while Req is high.
- Addr_A / Addr_B  in  ADDR_WIDTH  logical word address within the process partition.
- Data_A / Data_B  in  DATA_WIDTH  write data.
- PID_A / PID_B  in  PID_WIDTH  process ID.
- Ack_A / Ack_B  out  1  one-cycle completion pulse.
- Fault_A / Fault_B  out  1  out-of-partition pulse, coincident with Ack (see Configuration).
- Read_Data  out  DATA_WIDTH  read result; valid while Ack is high, held afterwards.
- Mem_Address  out  ADDR_WIDTH  physical RAM address.
- Mem_Write_Data  out  DATA_WIDTH  RAM write data.
- Mem_Write  out  1  RAM write enable.
- Mem_Read_Data  in  DATA_WIDTH  registered RAM read output.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE. All outputs are registered.
- IDLE:
  - A requester is eligible when its Req is high and its Ack is low this cycle. This stops a still-high Req from being regranted in the Ack cycle.
  - If no requester is eligible, stay in IDLE.
  - If one is eligible, grant it.
  - If both are eligible, grant the one not granted last. Priority after reset is A.
  - On grant, latch Write, Data and the physical address {PID, Addr[PART_WIDTH-1:0]}, zero-extended to ADDR_WIDTH, then go to ISSUE.
- ISSUE:
  - Mem_Address is driven from the latch.
  - Mem_Write is high only in this state, and only for a granted write.
  - Go to CAPTURE.
- CAPTURE:
  - Mem_Address is held.
  - Read_Data <= Mem_Read_Data for reads; unchanged for writes.
  - The granted requester's Ack pulses in the next cycle.
  - The last-grant register is updated.
  - Go to IDLE.
- A and B are never acked in the same cycle. Mem_Write is never high outside ISSUE.
- Write-then-read to the same address returns the new data.

## Timing
- Req sampled high at edge 0 → ISSUE in cycle 1 → CAPTURE in cycle 2 → Ack high in cycle 3. The next grant can occur at edge 3.
- Throughput: one access per 3 cycles. Two continuously requesting ports alternate A, B, A, …
- Reset (any state, including mid-access) takes effect at the next edge:
  - state = IDLE, last-grant = B (so A wins first);
  - Ack_A = Ack_B = Fault_A = Fault_B = 0, Mem_Write = 0;
  - Mem_Address = 0, Mem_Write_Data = 0, Read_Data = 0.
- An aborted ISSUE write produces no Mem_Write pulse after the Reset edge.

## Configuration
- RAM_ARBITER_BOUNDS_CHECK_EN defined:
  - If Addr[ADDR_WIDTH-1:PART_WIDTH] ≠ 0, the access is still granted and follows the full IDLE→ISSUE→CAPTURE timing.
  - Mem_Write stays 0 and Read_Data is set to 0.
  - Fault_x pulses together with Ack_x.
- Undefined: upper address bits are discarded (wrap within the partition) and Fault_A/Fault_B are tied 0.

## Structure
- Package ram_arbiter_pkg holds:
  - the state enum (IDLE, ISSUE, CAPTURE);
  - PART_WIDTH and PID_WIDTH defaults;
  - the grant-select encoding (GRANT_A, GRANT_B).
- One sub-module, rr_pick2: 2-way round-robin picker. Inputs are the eligible vector and last-grant; output is a one-hot grant.

## Test plan
- Reset, then single A write: PID_A=2, Addr_A=0x0005, Data_A=0xDEADBEEF → Mem_Address=0x0405 with Mem_Write high in cycle 1 only; Ack_A in cycle 3.
- A read of the same location → Read_Data=0xDEADBEEF coincident with Ack_A; Ack_B stays 0.
- Req_A and Req_B both held high for 12 cycles → Acks alternate A, B, A, B at cycles 3, 6, 9, 12.
- With the macro: Addr_B=0x0200, write → no Mem_Write pulse, Fault_B=Ack_B=1, Read_Data=0.
- Without the macro, same stimulus → Mem_Address={PID_B,9'h000}, write performed, Fault_B=0.
- Reset asserted during ISSUE of a write → next cycle Mem_Write=0, all Acks 0, state IDLE. A subsequent simultaneous request grants A first.
